// File: rtl/serializer_bidir.sv
// Parallel-in, serial-out transmitter with selectable bit order.
// Feeds a bidirectional serial-in shift register advanced on sout_valid.
module serializer_bidir #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             direccion,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             done_q, done_d;
  logic             last_bit;
  logic             accept;

  assign last_bit  = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign din_ready = (state_q == IDLE) || last_bit;
  assign accept    = din_valid && din_ready;

  // Next-state; outputs are precomputed from next state so they leave flops.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;

    if (state_q == SHIFT) begin
      sh_d  = dir_q ? (sh_q << 1) : (sh_q >> 1);
      cnt_d = cnt_q + CNT_W'(1);
      if (last_bit) begin
        state_d = IDLE;
      end
    end

    if (accept) begin
      sh_d    = din;
      dir_d   = direccion;
      cnt_d   = '0;
      state_d = SHIFT;
    end

    sout_valid_d = (state_d == SHIFT);
    sout_d       = sout_valid_d && (dir_d ? sh_d[WIDTH-1] : sh_d[0]);
    done_d       = sout_valid_d && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sh_q         <= '0;
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      done_q       <= done_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_serializer_bidir.sv
// Directed bench for serializer_bidir with a 4-bit receiving shift register model.
module tb_serializer_bidir;

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       direccion;
  logic       sout;
  logic       sout_valid;
  logic       done;

  logic [3:0] rx;
  logic       rx_dir;

  int checks;
  int errors;

  serializer_bidir #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .direccion  (direccion),
    .sout       (sout),
    .sout_valid (sout_valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Receiving shift register: shifts only on sout_valid, same bit-order mode.
  always @(posedge clk) begin
    if (sout_valid) begin
      rx <= rx_dir ? {rx[2:0], sout} : {sout, rx[3:1]};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sends one word; exp[3] is the first serial bit expected.
  task automatic run_frame(input logic [3:0] w, input logic d, input logic [3:0] exp,
                           input bit toggle, input bit chk_rx);
    @(negedge clk);
    check("idle_ready", 32'(din_ready), 32'd1);
    din       = w;
    direccion = d;
    din_valid = 1'b1;
    rx_dir    = d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) din_valid = 1'b0;
      check("frame_valid", 32'(sout_valid), 32'd1);
      check("frame_bit", 32'(sout), 32'(exp[3-i]));
      check("frame_done", 32'(done), 32'(i == 3));
      check("frame_ready", 32'(din_ready), 32'(i == 3));
      if (toggle) direccion = ~direccion;
    end
    @(negedge clk);
    check("post_valid", 32'(sout_valid), 32'd0);
    check("post_done", 32'(done), 32'd0);
    check("post_ready", 32'(din_ready), 32'd1);
    if (chk_rx) check("loopback", 32'(rx), 32'(w));
  endtask

  initial begin
    logic [3:0] w;
    logic [3:0] e;
    logic [7:0] b2b;
    clk       = 1'b0;
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    direccion = 1'b0;
    rx        = '0;
    rx_dir    = 1'b0;
    checks    = 0;
    errors    = 0;

    @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(din_ready), 32'd1);
    check("rst_valid", 32'(sout_valid), 32'd0);
    check("rst_sout", 32'(sout), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_ready", 32'(din_ready), 32'd1);
      check("idle_valid", 32'(sout_valid), 32'd0);
      check("idle_sout", 32'(sout), 32'd0);
      check("idle_done", 32'(done), 32'd0);
    end

    run_frame(4'b1011, 1'b1, 4'b1011, 1'b0, 1'b1);
    run_frame(4'b1011, 1'b0, 4'b1101, 1'b0, 1'b1);
    run_frame(4'b0110, 1'b0, 4'b0110, 1'b1, 1'b0);

    // Back-to-back frames: 1000 then 0001, MSB first.
    b2b = 8'b1000_0001;
    @(negedge clk);
    din       = 4'b1000;
    direccion = 1'b1;
    din_valid = 1'b1;
    rx_dir    = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("b2b_valid", 32'(sout_valid), 32'd1);
      check("b2b_bit", 32'(sout), 32'(b2b[8-i]));
      check("b2b_done", 32'(done), 32'((i == 4) || (i == 8)));
      check("b2b_ready", 32'(din_ready), 32'((i == 4) || (i == 8)));
      if (i == 1) din = 4'b0001;
      if (i == 8) din_valid = 1'b0;
    end
    @(negedge clk);
    check("b2b_end_valid", 32'(sout_valid), 32'd0);
    check("b2b_end_ready", 32'(din_ready), 32'd1);
    check("b2b_rx", 32'(rx), 32'h1);

    // Reset during the second bit of 1111 aborts the frame.
    @(negedge clk);
    din       = 4'b1111;
    direccion = 1'b1;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    check("abort_bit1", 32'(sout), 32'd1);
    @(negedge clk);
    check("abort_bit2", 32'(sout_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_valid", 32'(sout_valid), 32'd0);
    check("abort_sout", 32'(sout), 32'd0);
    check("abort_ready", 32'(din_ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_idle", 32'(sout_valid), 32'd0);
    end
    run_frame(4'b0101, 1'b1, 4'b0101, 1'b0, 1'b1);

    // Loopback with random words in both bit orders.
    for (int d = 1; d >= 0; d--) begin
      for (int n = 0; n < 16; n++) begin
        w = 4'($urandom_range(0, 15));
        e = (d == 1) ? w : {w[0], w[1], w[2], w[3]};
        run_frame(w, 1'(d), e, 1'b0, 1'b1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serializer_bidir.md
# serializer_bidir

Parallel-in, serial-out transmitter that feeds the team's 4-bit bidirectional serial-in shift register. It accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on `sout`. `direccion` selects the bit order, so the receiving shift register, running in the same `direccion` mode and advanced only on `sout_valid` cycles, ends holding the original word. It sits between the parallel data source and the serial link.

## Interface

- `WIDTH`, default 4: word length in bits; legal range ≥ 2.
- `clk`  input  1: single clock; all state updates on rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `din`  input  WIDTH: parallel word to transmit.
- `din_valid`  input  1: source has a word on `din`.
- `din_ready`  output  1: block can accept a word this cycle.
- `direccion`  input  1: bit order. 1 sends bit WIDTH-1 first, descending. 0 sends bit 0 first, ascending. Sampled only on acceptance.
- `sout`  output  1: serial data bit.
- `sout_valid`  output  1: `sout` carries a frame bit this cycle. Receiver's shift enable.
- `done`  output  1: one-cycle pulse coincident with the last bit of a frame.

## Operation

- Registers:
  - shift register `sh[WIDTH-1:0]`
  - latched direction `dir_q`
  - bit counter `cnt`, width clog2(WIDTH)
  - state {IDLE, SHIFT}
- Accept condition: `din_valid && din_ready` at a rising edge. On accept:
  - `sh` ← `din`
  - `dir_q` ← `direccion`
  - `cnt` ← 0
  - state ← SHIFT
- Handshake:
  - `din_ready` = (state==IDLE) || (state==SHIFT && cnt==WIDTH-1). It is combinational from state.
  - `din_valid` while `din_ready`=0 is ignored. The word is not captured; the source must hold it.
- SHIFT, each cycle:
  - `sout` = `dir_q` ? `sh[WIDTH-1]` : `sh[0]`
  - `sout_valid`=1
  - At the edge, `sh` shifts toward the output end: left when `dir_q`=1, right when `dir_q`=0. Fill bit is 0.
  - `cnt` increments.
- Last bit (cnt==WIDTH-1):
  - `done`=1.
  - At the edge: a new word is accepted if `din_valid`=1 (state stays SHIFT, `cnt` ← 0); otherwise state ← IDLE.
- IDLE outputs: `sout`=0, `sout_valid`=0, `done`=0.
- `direccion` changes during SHIFT have no effect on the current frame.
- Frame length is exactly WIDTH bits. There are no start/stop bits.

## Timing

- Reset values, applied at the first rising edge with `rst`=1:
  - state=IDLE, `sh`=0, `cnt`=0, `dir_q`=0
  - `sout`=0, `sout_valid`=0, `done`=0, `din_ready`=1
- `rst` overrides everything, including an accept in the same cycle.
- Reset mid-frame aborts the frame: remaining bits are never sent, and `done` does not pulse for that frame.
- Latency: word accepted at edge k → first bit valid in cycle k+1 → last bit (with `done`) in cycle k+WIDTH.
- Back-to-back: accept at the last-bit edge gives gapless streaming, WIDTH bits per WIDTH cycles, with `sout_valid` held high continuously.
- Throughput without back-to-back (source raises `din_valid` only in IDLE): one idle cycle between frames.
- Outputs `sout`, `sout_valid`, `done` depend only on registered state; there is no combinational path from inputs.

## Test plan

- Reset, then hold `din_valid`=0 for 5 cycles → `din_ready`=1, `sout_valid`=0, `sout`=0, `done`=0 throughout.
- WIDTH=4, `din`=4'b1011, `direccion`=1 → `sout` = 1,0,1,1 over 4 consecutive `sout_valid` cycles starting one cycle after accept; `done` only on the 4th; return to IDLE.
- `din`=4'b1011, `direccion`=0 → `sout` = 1,1,0,1. Then `din`=4'b0110 with `direccion`=0 and `direccion` toggled every cycle mid-frame → `sout` = 0,1,1,0 (toggles ignored).
- Back-to-back: `din_valid` held high with 4'b1000 then 4'b0001, `direccion`=1 → `sout` = 1,0,0,0,0,0,0,1 with `sout_valid` high for 8 consecutive cycles; `done` in cycles 4 and 8; `din_ready` high only in IDLE and in cycles 4 and 8.
- Reset asserted during the 2nd bit of 4'b1111 → next cycle `sout_valid`=0, `sout`=0, `din_ready`=1; no `done` pulse. A subsequent word 4'b0101 with `direccion`=1 is sent cleanly as 0,1,0,1.
- Loopback: connect `sout` to the receiver's serial input, clocked so it shifts only when `sout_valid`=1. Send 16 random 4-bit words in each `direccion` → receiver parallel output equals `din` after each `done`.
